// File: rtl/ex_issue_ctrl.sv
// ex_issue_ctrl: issue/latency controller between the ID/EX register and MEM.
// Tracks one op in flight, counts down its EX latency, registers the result
// for MEM and raises a one-cycle redirect pulse when the datapath asks for it.
//
//  state | meaning
//  ------+-----------------------------------------------------------
//  IDLE  | nothing in flight, no pending result; ready for a new op
//  EXEC  | op in EX, cnt counts remaining cycles down to zero
//  HOLD  | result registered, waiting for MEM to take it
module ex_issue_ctrl #(
  parameter int unsigned MUL_LAT    = 3,
  parameter int unsigned DIV_LAT    = 8,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  output logic                  id_ready,
  input  logic [6:0]            id_opcode,
  input  logic                  id_is_word_op,
  output logic [6:0]            ex_opcode,
  input  logic [DATA_WIDTH-1:0] ex_res,
  input  logic                  ex_jump_signal,
  input  logic [ADDR_WIDTH-1:0] ex_jump_pc,
  output logic                  mem_valid,
  input  logic                  mem_ready,
  output logic [DATA_WIDTH-1:0] mem_res,
  output logic                  flush,
  output logic [ADDR_WIDTH-1:0] flush_pc,
  output logic                  busy,
  output logic [31:0]           stall_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  localparam int unsigned DIVW_LAT = (DIV_LAT / 2 < 1) ? 1 : DIV_LAT / 2;

  // Counter preload is latency minus one: the capture happens on the edge
  // after the counter reaches zero.
  localparam logic [3:0] MUL_CNT  = 4'(MUL_LAT - 1);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_LAT - 1);
  localparam logic [3:0] DIVW_CNT = 4'(DIVW_LAT - 1);

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [6:0]            ex_opcode_q, ex_opcode_d;
  logic                  mem_valid_q, mem_valid_d;
  logic [DATA_WIDTH-1:0] mem_res_q, mem_res_d;
  logic                  flush_q, flush_d;
  logic [ADDR_WIDTH-1:0] flush_pc_q, flush_pc_d;
  logic [31:0]           stall_cnt_q, stall_cnt_d;

  logic       issue;
  logic [3:0] lat_cnt;

  // A NOP is accepted (consumes the ID slot) but never starts execution.
  assign issue = id_valid && id_ready && (id_opcode != 7'd0);

  // Latency preload for the op currently presented by ID.
  always_comb begin
    lat_cnt = 4'd0;
    case (id_opcode)
      7'd6, 7'd7: lat_cnt = MUL_CNT;
      7'd8, 7'd9: lat_cnt = id_is_word_op ? DIVW_CNT : DIV_CNT;
      default:    lat_cnt = 4'd0;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (issue) state_d = S_EXEC;
      S_EXEC: if (cnt_q == 4'd0) state_d = S_HOLD;
      S_HOLD: if (mem_ready) state_d = issue ? S_EXEC : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM-decoded outputs; the redirect cycle blocks the wrong-path op.
  always_comb begin
    id_ready = 1'b0;
    busy     = (state_q != S_IDLE);
    case (state_q)
      S_IDLE:  id_ready = 1'b1;
      S_HOLD:  id_ready = mem_ready && !flush_q;
      default: id_ready = 1'b0;
    endcase
  end

  // Datapath next values: latency counter, result capture, redirect, stall count.
  always_comb begin
    cnt_d       = cnt_q;
    ex_opcode_d = ex_opcode_q;
    mem_valid_d = mem_valid_q;
    mem_res_d   = mem_res_q;
    flush_d     = 1'b0;
    flush_pc_d  = flush_pc_q;
    stall_cnt_d = stall_cnt_q;

    if (id_valid && !id_ready && (stall_cnt_q != 32'hFFFF_FFFF))
      stall_cnt_d = stall_cnt_q + 32'd1;

    if ((state_q == S_HOLD) && mem_ready)
      mem_valid_d = 1'b0;

    if (state_q == S_EXEC) begin
      if (cnt_q == 4'd0) begin
        mem_res_d   = ex_res;
        mem_valid_d = 1'b1;
        ex_opcode_d = 7'd0;
        if (ex_jump_signal) begin
          flush_d    = 1'b1;
          flush_pc_d = ex_jump_pc;
        end
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
    end

    if (issue) begin
      ex_opcode_d = id_opcode;
      cnt_d       = lat_cnt;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q       <= 4'd0;
      ex_opcode_q <= 7'd0;
      mem_valid_q <= 1'b0;
      mem_res_q   <= '0;
      flush_q     <= 1'b0;
      flush_pc_q  <= '0;
      stall_cnt_q <= 32'd0;
    end else begin
      cnt_q       <= cnt_d;
      ex_opcode_q <= ex_opcode_d;
      mem_valid_q <= mem_valid_d;
      mem_res_q   <= mem_res_d;
      flush_q     <= flush_d;
      flush_pc_q  <= flush_pc_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign ex_opcode = ex_opcode_q;
  assign mem_valid = mem_valid_q;
  assign mem_res   = mem_res_q;
  assign flush     = flush_q;
  assign flush_pc  = flush_pc_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_ex_issue_ctrl.sv
// tb_ex_issue_ctrl: random issue traffic against a latency-based reference model.
// The model tracks "op in flight with result due at edge N" rather than states.
module tb_ex_issue_ctrl;

  localparam int unsigned MUL_LAT = 3;
  localparam int unsigned DIV_LAT = 8;
  localparam int unsigned DW      = 64;
  localparam int unsigned AW      = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic          id_valid;
  logic          id_ready;
  logic [6:0]    id_opcode;
  logic          id_is_word_op;
  logic [6:0]    ex_opcode;
  logic [DW-1:0] ex_res;
  logic          ex_jump_signal;
  logic [AW-1:0] ex_jump_pc;
  logic          mem_valid;
  logic          mem_ready;
  logic [DW-1:0] mem_res;
  logic          flush;
  logic [AW-1:0] flush_pc;
  logic          busy;
  logic [31:0]   stall_cnt;

  ex_issue_ctrl #(
    .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_opcode(id_opcode), .id_is_word_op(id_is_word_op),
    .ex_opcode(ex_opcode), .ex_res(ex_res),
    .ex_jump_signal(ex_jump_signal), .ex_jump_pc(ex_jump_pc),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_res(mem_res),
    .flush(flush), .flush_pc(flush_pc), .busy(busy), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int          edge_n;
  bit          m_inflight;
  logic [6:0]  m_op;
  int          m_done_edge;
  bit          m_rv;
  logic [63:0] m_res;
  bit          m_flush;
  logic [63:0] m_fpc;
  logic [31:0] m_stall;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s @%0t: got=%0h want=%0h", tag, $time, act, exp_v);
    end
  endtask

  function automatic int lat_of(input logic [6:0] op, input logic w);
    int h;
    h = DIV_LAT / 2;
    if (h < 1) h = 1;
    if (op == 7'd6 || op == 7'd7) return MUL_LAT;
    if (op == 7'd8 || op == 7'd9) return w ? h : DIV_LAT;
    return 1;
  endfunction

  function automatic bit m_ready();
    return (!m_inflight && !m_rv) || (m_rv && mem_ready && !m_flush);
  endfunction

  task automatic model_reset();
    m_inflight = 0; m_op = '0; m_done_edge = 0; m_rv = 0; m_res = '0;
    m_flush = 0; m_fpc = '0; m_stall = '0;
  endtask

  // Advance the model across one active edge using the inputs held during the cycle.
  task automatic model_step();
    bit rdy;
    bit nf;
    rdy = m_ready();
    nf  = 0;
    edge_n++;
    if (id_valid && !rdy && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
    if (m_rv && mem_ready) m_rv = 0;
    if (m_inflight && edge_n == m_done_edge) begin
      m_inflight = 0;
      m_rv       = 1;
      m_res      = ex_res;
      if (ex_jump_signal) begin
        nf    = 1;
        m_fpc = ex_jump_pc;
      end
    end
    if (id_valid && rdy && id_opcode != 7'd0) begin
      m_inflight  = 1;
      m_op        = id_opcode;
      m_done_edge = edge_n + lat_of(id_opcode, id_is_word_op);
    end
    m_flush = nf;
  endtask

  task automatic check_outputs(input string pfx);
    check_val({pfx, "_id_ready"},  64'(id_ready),  64'(m_ready()));
    check_val({pfx, "_ex_opcode"}, 64'(ex_opcode), m_inflight ? 64'(m_op) : 64'd0);
    check_val({pfx, "_mem_valid"}, 64'(mem_valid), 64'(m_rv));
    check_val({pfx, "_mem_res"},   mem_res,        m_res);
    check_val({pfx, "_flush"},     64'(flush),     64'(m_flush));
    check_val({pfx, "_flush_pc"},  flush_pc,       m_fpc);
    check_val({pfx, "_busy"},      64'(busy),      64'(m_inflight || m_rv));
    check_val({pfx, "_stall_cnt"}, 64'(stall_cnt), 64'(m_stall));
  endtask

  task automatic drive_random();
    int sel;
    id_valid  = ($urandom_range(0, 9) < 7);
    sel       = $urandom_range(0, 9);
    case (sel)
      0:       id_opcode = 7'd0;
      1, 2:    id_opcode = 7'd1;
      3:       id_opcode = 7'd6;
      4:       id_opcode = 7'd7;
      5:       id_opcode = 7'd8;
      6:       id_opcode = 7'd9;
      7:       id_opcode = 7'd13;
      default: id_opcode = 7'($urandom_range(0, 127));
    endcase
    id_is_word_op  = $urandom_range(0, 1) == 1;
    ex_res         = {$urandom, $urandom};
    ex_jump_signal = ($urandom_range(0, 3) == 0);
    ex_jump_pc     = {$urandom, $urandom};
    mem_ready      = ($urandom_range(0, 9) < 7);
  endtask

  initial begin
    reset = 1'b0;
    id_valid = 0; id_opcode = '0; id_is_word_op = 0; ex_res = '0;
    ex_jump_signal = 0; ex_jump_pc = '0; mem_ready = 0;
    edge_n = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs("rst");
    reset = 1'b1;

    for (int i = 0; i < 4000; i++) begin
      drive_random();
      if ($urandom_range(0, 149) == 0) begin
        // Asynchronous reset between edges: outputs must clear without a clock.
        #1 reset = 1'b0;
        #1;
        model_reset();
        check_outputs("arst");
        @(posedge clk);
        #1 reset = 1'b1;
        continue;
      end
      @(negedge clk);
      check_outputs("run");
      @(posedge clk);
      model_step();
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
